// File: rtl/lbp_stream_encoder_pkg.sv
// hdc_lbp_pkg: shared types and helpers for the streaming LBP window encoder.
//   lbp_state_t : encoder FSM state (WARMUP fills sample history, RUN encodes)
//   num_lbp     : number of LBP item HVs for a given pattern width
//   num_acc     : number of overlapping window accumulator banks
//   cnt_width   : bit width of one accumulator counter
//   idx_width   : bit width of a counter running 0..n-1 (at least 1)
//   chan_major  : per-bit channel bundling rule (tie takes channel 0's bit)
//   win_major   : per-bit window threshold rule (tie gives 0)
package hdc_lbp_pkg;

  typedef enum logic {WARMUP, RUN} lbp_state_t;

  function automatic int unsigned num_lbp(input int unsigned lbp_size);
    return 32'(1) << lbp_size;
  endfunction

  function automatic int unsigned num_acc(input int unsigned window_size,
                                          input int unsigned window_step);
    return window_size / window_step;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned window_size);
    return $clog2(window_size + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic chan_major(input int unsigned ones,
                                      input int unsigned num_chs,
                                      input logic        tie_bit);
    if (2 * ones > num_chs) return 1'b1;
    if (2 * ones == num_chs) return tie_bit;
    return 1'b0;
  endfunction

  function automatic logic win_major(input int unsigned count,
                                     input int unsigned window_size);
    return (2 * count > window_size);
  endfunction

endpackage

// File: rtl/lbp_window_accumulator.sv
// lbp_window_accumulator: one bank of per-bit counters for a window HV.
// Ports:
//   clk, nrst    : clock, synchronous active-low reset
//   arm          : clear and start this bank; the current sample is counted
//   add          : a sample HV is presented this cycle (counted if armed)
//   done         : window completes this cycle; bank clears and disarms
//   sample_hv    : current sample HV
//   armed        : bank is collecting a window
//   window_bits  : thresholded counts including the current sample
module lbp_window_accumulator
  import hdc_lbp_pkg::*;
#(
  parameter int unsigned DIMENSIONS  = 10000,
  parameter int unsigned WINDOW_SIZE = 256
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  arm,
  input  logic                  add,
  input  logic                  done,
  input  logic [DIMENSIONS-1:0] sample_hv,
  output logic                  armed,
  output logic [DIMENSIONS-1:0] window_bits
);

  localparam int unsigned CNT_W = cnt_width(WINDOW_SIZE);

  logic [CNT_W-1:0] cnt [DIMENSIONS];
  logic [CNT_W-1:0] sum [DIMENSIONS];

  // Arming restarts from zero so the arming sample is the first one counted.
  always_comb begin
    window_bits = '0;
    for (int unsigned d = 0; d < DIMENSIONS; d++) begin
      sum[d] = (arm ? '0 : cnt[d]) + CNT_W'(sample_hv[d]);
      window_bits[d] = win_major(32'(sum[d]), WINDOW_SIZE);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst || done) begin
      armed <= 1'b0;
      for (int unsigned d = 0; d < DIMENSIONS; d++) cnt[d] <= '0;
    end else if (arm) begin
      armed <= 1'b1;
      for (int unsigned d = 0; d < DIMENSIONS; d++) cnt[d] <= sum[d];
    end else if (add && armed) begin
      for (int unsigned d = 0; d < DIMENSIONS; d++) cnt[d] <= sum[d];
    end
  end

endmodule

// File: rtl/lbp_stream_encoder.sv
// lbp_stream_encoder: streaming multichannel LBP encoder producing
// overlapping bundled window HVs.
// Ports:
//   clk, nrst          : clock, synchronous active-low reset
//   in_valid/in_ready  : sample handshake (in_ready = !out_valid || out_ready)
//   samples            : signed samples, channel c at [c*SAMPLE_W +: SAMPLE_W]
//   ch_hv, lbp_hv      : static channel / LBP item HVs
//   out_valid/out_ready: window handshake
//   window_hv          : bundled window HV, held while stalled
// Optional (LBP_SAMPLE_TAP_EN defined):
//   sample_hv_tap      : registered copy of each RUN sample HV
//   sample_tap_valid   : one-cycle pulse after each RUN accept
module lbp_stream_encoder
  import hdc_lbp_pkg::*;
#(
  parameter int unsigned DIMENSIONS  = 10000,
  parameter int unsigned NUM_CHS     = 17,
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned LBP_SIZE    = 6,
  parameter int unsigned WINDOW_SIZE = 256,
  parameter int unsigned WINDOW_STEP = 128
) (
  input  logic                                          clk,
  input  logic                                          nrst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [NUM_CHS*SAMPLE_W-1:0]                   samples,
  input  logic [NUM_CHS*DIMENSIONS-1:0]                 ch_hv,
  input  logic [num_lbp(LBP_SIZE)*DIMENSIONS-1:0]       lbp_hv,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [DIMENSIONS-1:0]                         window_hv
`ifdef LBP_SAMPLE_TAP_EN
  ,
  output logic [DIMENSIONS-1:0]                         sample_hv_tap,
  output logic                                          sample_tap_valid
`endif
);

  localparam int unsigned NUM_LBP = num_lbp(LBP_SIZE);
  localparam int unsigned NUM_ACC = num_acc(WINDOW_SIZE, WINDOW_STEP);
  localparam int unsigned IDX_W   = idx_width(WINDOW_SIZE);
  localparam int unsigned WARM_W  = idx_width(LBP_SIZE);

  lbp_state_t state, state_nx;
  logic [WARM_W-1:0] warm_cnt;
  logic [IDX_W-1:0]  idx;
  logic              accept, run_acc, fire;

  logic signed [SAMPLE_W-1:0] samp [NUM_CHS];
  logic signed [SAMPLE_W-1:0] hist [NUM_CHS][LBP_SIZE];
  logic signed [SAMPLE_W-1:0] win  [NUM_CHS][LBP_SIZE+1];
  logic [LBP_SIZE-1:0]        pattern [NUM_CHS];
  logic [DIMENSIONS-1:0]      ch_arr [NUM_CHS];
  logic [DIMENSIONS-1:0]      lbp_arr [NUM_LBP];
  logic [DIMENSIONS-1:0]      bound [NUM_CHS];
  logic [DIMENSIONS-1:0]      sample_hv;
  int unsigned                ones;

  logic [NUM_ACC-1:0]    arm, done, armed;
  logic [DIMENSIONS-1:0] bank_bits [NUM_ACC];
  logic [DIMENSIONS-1:0] sel_bits;
  int unsigned           nxt;

  for (genvar c = 0; c < NUM_CHS; c++) begin : g_ch
    assign samp[c]   = samples[c*SAMPLE_W +: SAMPLE_W];
    assign ch_arr[c] = ch_hv[c*DIMENSIONS +: DIMENSIONS];
  end
  for (genvar l = 0; l < NUM_LBP; l++) begin : g_lbp
    assign lbp_arr[l] = lbp_hv[l*DIMENSIONS +: DIMENSIONS];
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign run_acc  = accept && (state == RUN);

  always_ff @(posedge clk) begin
    if (!nrst) state <= WARMUP;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WARMUP:  if (accept && warm_cnt == WARM_W'(LBP_SIZE - 1)) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = WARMUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst)                          warm_cnt <= '0;
    else if (accept && state == WARMUP) warm_cnt <= warm_cnt + WARM_W'(1);
  end

  // Only the LBP_SIZE older samples are registered; the incoming sample is the
  // newest history entry, so the pattern sees the full LBP_SIZE+1 history in
  // the accepting cycle.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CHS; c++) begin
      for (int unsigned i = 0; i < LBP_SIZE; i++) win[c][i] = hist[c][i];
      win[c][LBP_SIZE] = samp[c];
      pattern[c] = '0;
      for (int unsigned j = 1; j <= LBP_SIZE; j++)
        pattern[c][j-1] = (win[c][j] <= win[c][j-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int unsigned c = 0; c < NUM_CHS; c++)
        for (int unsigned i = 0; i < LBP_SIZE; i++) hist[c][i] <= '0;
    end else if (accept) begin
      for (int unsigned c = 0; c < NUM_CHS; c++)
        for (int unsigned i = 0; i < LBP_SIZE; i++) hist[c][i] <= win[c][i+1];
    end
  end

  always_comb begin
    sample_hv = '0;
    ones      = 0;
    for (int unsigned c = 0; c < NUM_CHS; c++)
      bound[c] = lbp_arr[pattern[c]] ^ ch_arr[c];
    for (int unsigned d = 0; d < DIMENSIONS; d++) begin
      ones = 0;
      for (int unsigned c = 0; c < NUM_CHS; c++) if (bound[c][d]) ones++;
      sample_hv[d] = chan_major(ones, NUM_CHS, bound[0][d]);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst)        idx <= '0;
    else if (run_acc) idx <= (idx == IDX_W'(WINDOW_SIZE - 1)) ? '0 : idx + IDX_W'(1);
  end

  // Bank k opens at idx == k*STEP; the bank whose window ends on this sample
  // is the one that will reopen on the next index.
  always_comb begin
    arm      = '0;
    done     = '0;
    sel_bits = '0;
    nxt      = 32'(idx) + 1;
    if (run_acc) begin
      for (int unsigned k = 0; k < NUM_ACC; k++) begin
        if (idx == IDX_W'(k * WINDOW_STEP)) arm[k] = 1'b1;
        if ((nxt % WINDOW_STEP == 0) && (k == (nxt / WINDOW_STEP) % NUM_ACC))
          done[k] = armed[k];
      end
    end
    for (int unsigned k = 0; k < NUM_ACC; k++)
      if (done[k]) sel_bits = bank_bits[k];
  end

  assign fire = |done;

  for (genvar g = 0; g < NUM_ACC; g++) begin : g_acc
    lbp_window_accumulator #(
      .DIMENSIONS (DIMENSIONS),
      .WINDOW_SIZE(WINDOW_SIZE)
    ) u_acc (
      .clk        (clk),
      .nrst       (nrst),
      .arm        (arm[g]),
      .add        (run_acc),
      .done       (done[g]),
      .sample_hv  (sample_hv),
      .armed      (armed[g]),
      .window_bits(bank_bits[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      out_valid <= 1'b0;
      window_hv <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      window_hv <= sel_bits;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LBP_SAMPLE_TAP_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sample_hv_tap    <= '0;
      sample_tap_valid <= 1'b0;
    end else begin
      sample_tap_valid <= run_acc;
      if (run_acc) sample_hv_tap <= sample_hv;
    end
  end
`endif

endmodule

// File: tb/tb_lbp_stream_encoder.sv
// Testbench for lbp_stream_encoder with a small configuration and a
// sample-list reference model. Define LBP_SAMPLE_TAP_EN to cover the tap.
module tb_lbp_stream_encoder;

  localparam int D = 16, C = 3, SW = 8, L = 2, WS = 4, WST = 2, NL = 4;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [C*SW-1:0] samples = '0;
  logic [C*D-1:0]  ch_hv;
  logic [NL*D-1:0] lbp_hv;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [D-1:0]    window_hv;
`ifdef LBP_SAMPLE_TAP_EN
  logic [D-1:0]    sample_hv_tap;
  logic            sample_tap_valid;
`endif

  lbp_stream_encoder #(
    .DIMENSIONS (D),
    .NUM_CHS    (C),
    .SAMPLE_W   (SW),
    .LBP_SIZE   (L),
    .WINDOW_SIZE(WS),
    .WINDOW_STEP(WST)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .samples  (samples),
    .ch_hv    (ch_hv),
    .lbp_hv   (lbp_hv),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .window_hv(window_hv)
`ifdef LBP_SAMPLE_TAP_EN
    ,
    .sample_hv_tap   (sample_hv_tap),
    .sample_tap_valid(sample_tap_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  logic [D-1:0] ch_t [C];
  logic [D-1:0] lbp_t [NL];

  // reference model state
  int           mh [C][L+1];
  int           nacc;
  logic [D-1:0] shv [$];
  logic         exp_valid;
  logic [D-1:0] exp_win;
  logic         exp_tap;
  logic [D-1:0] exp_tap_hv;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < C; c++)
      for (int j = 0; j <= L; j++) mh[c][j] = 0;
    nacc = 0;
    shv.delete();
    exp_valid = 1'b0;
    exp_win = '0;
    exp_tap = 1'b0;
    exp_tap_hv = '0;
  endtask

  // majority over channels of l ^ ch_t[c], tie takes channel 0
  function automatic logic [D-1:0] maj_ch(input logic [D-1:0] l);
    logic [D-1:0] r;
    int ones;
    r = '0;
    for (int d = 0; d < D; d++) begin
      ones = 0;
      for (int c = 0; c < C; c++) ones += int'(l[d] ^ ch_t[c][d]);
      r[d] = (2 * ones > C) ? 1'b1 : ((2 * ones == C) ? (l[d] ^ ch_t[0][d]) : 1'b0);
    end
    return r;
  endfunction

  task automatic model_accept(input logic [C*SW-1:0] s, output logic fire, output logic [D-1:0] w);
    logic signed [SW-1:0] v;
    logic [D-1:0] hv;
    int pat [C];
    int ones, b0, bit_v, m, cnt;
    fire = 1'b0;
    w = '0;
    for (int c = 0; c < C; c++) begin
      for (int j = 0; j < L; j++) mh[c][j] = mh[c][j+1];
      v = s[c*SW +: SW];
      mh[c][L] = v;
    end
    nacc++;
    if (nacc > L) begin
      for (int c = 0; c < C; c++) begin
        pat[c] = 0;
        for (int j = 1; j <= L; j++) if (mh[c][j] <= mh[c][j-1]) pat[c] += (1 << (j - 1));
      end
      hv = '0;
      for (int d = 0; d < D; d++) begin
        ones = 0;
        b0 = 0;
        for (int c = 0; c < C; c++) begin
          bit_v = int'(lbp_t[pat[c]][d] ^ ch_t[c][d]);
          if (c == 0) b0 = bit_v;
          ones += bit_v;
        end
        hv[d] = (2 * ones > C) ? 1'b1 : ((2 * ones == C) ? (b0 != 0) : 1'b0);
      end
      shv.push_back(hv);
      if (shv.size() > WS) void'(shv.pop_front());
      exp_tap = 1'b1;
      exp_tap_hv = hv;
      m = nacc - L;
      if (m >= WS && (m - WS) % WST == 0) begin
        fire = 1'b1;
        for (int d = 0; d < D; d++) begin
          cnt = 0;
          foreach (shv[i]) cnt += int'(shv[i][d]);
          w[d] = (2 * cnt > WS);
        end
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [C*SW-1:0] s, input logic rdy);
    logic acc, fire;
    logic [D-1:0] w;
    in_valid = v;
    samples = s;
    out_ready = rdy;
    @(negedge clk);
    check("in_ready", in_ready, !exp_valid || rdy);
    acc = v && (!exp_valid || rdy);
    @(posedge clk);
    fire = 1'b0;
    w = '0;
    exp_tap = 1'b0;
    if (acc) model_accept(s, fire, w);
    if (fire) begin
      exp_valid = 1'b1;
      exp_win = w;
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
    #1;
    check("out_valid", out_valid, exp_valid);
    check("window_hv", window_hv, exp_win);
`ifdef LBP_SAMPLE_TAP_EN
    check("tap_valid", sample_tap_valid, exp_tap);
    if (exp_tap) check("tap_hv", sample_hv_tap, exp_tap_hv);
`endif
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    model_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_window_hv", window_hv, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef LBP_SAMPLE_TAP_EN
    check("rst_tap_valid", sample_tap_valid, 0);
`endif
  endtask

  function automatic logic [C*SW-1:0] rep(input int x);
    logic [SW-1:0] t;
    t = SW'(x);
    return {C{t}};
  endfunction

  initial begin
    logic [D-1:0] held;
    logic [D-1:0] alt_win;
    logic [C*SW-1:0] s;
    logic [SW-1:0] b;
    logic v, rdy;
    int gap;

    for (int c = 0; c < C; c++) begin
      ch_t[c] = D'($urandom);
      ch_hv[c*D +: D] = ch_t[c];
    end
    for (int l = 0; l < NL; l++) begin
      lbp_t[l] = D'($urandom);
      lbp_hv[l*D +: D] = lbp_t[l];
    end

    do_reset();

    // ramp: pattern 0 everywhere, windows after accepts 6, 8, 10, 12
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, rep(i), 1'b1);
      if (i == 5) check("ramp_not_early", out_valid, 0);
      if (i == 6 || i == 8 || i == 10 || i == 12) begin
        check("ramp_valid", out_valid, 1);
        check("ramp_win", window_hv, maj_ch(lbp_t[0]));
      end
    end

    // constant samples: equal counts as falling, pattern 3
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, rep(5), 1'b1);
      if (i == 6 || i == 8) check("const_win", window_hv, maj_ch(lbp_t[3]));
    end

    // alternating up/down: sample HVs alternate, window = A & B
    do_reset();
    alt_win = maj_ch(lbp_t[1]) & maj_ch(lbp_t[2]);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, rep((i % 2 == 1) ? 0 : 9), 1'b1);
      if (i == 6 || i == 8) check("alt_win", window_hv, alt_win);
    end

    // backpressure on the first window
    do_reset();
    for (int i = 1; i <= 6; i++) cyc(1'b1, rep(i), 1'b0);
    check("bp_valid", out_valid, 1);
    held = window_hv;
    for (int t = 0; t < 10; t++) begin
      cyc(1'b1, rep(7), 1'b0);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", window_hv, held);
    end
    gap = 0;
    for (int t = 0; t < 8; t++) begin
      cyc(1'b1, rep(7 + gap), 1'b1);
      gap++;
      if (out_valid) break;
    end
    check("bp_gap", gap, 2);

    // reset in the middle of the first window
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, rep(i), 1'b1);
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, rep(20 + i), 1'b1);
      check("rst_restart_valid", out_valid, (i == 6));
    end

    // randomized traffic with random stalls on both sides
    do_reset();
    for (int t = 0; t < 400; t++) begin
      v = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < C; c++) begin
        b = (t < 200) ? SW'($urandom_range(0, 3)) : SW'($urandom);
        s[c*SW +: SW] = b;
      end
      cyc(v, s, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lbp_stream_encoder.md
Name: lbp_stream_encoder

Overview:
Parametrised streaming successor to the fixed LBP window encoder. Accepts one fixed-point multichannel sample per handshake and forms a per-channel LBP pattern. Binds each pattern HV with its channel HV (XOR) and bundles the channels into a sample HV. Overlapping window HVs are built with counter-based accumulators, so per-sample HVs are never stored. Sits between the ADC/sample front end and the associative-memory classifier.

Parameters:
DIMENSIONS, 10000, HV width in bits
NUM_CHS, 17, number of channels
SAMPLE_W, 16, signed fixed-point sample width
LBP_SIZE, 6, pattern bits; NUM_LBP = 2**LBP_SIZE (localparam)
WINDOW_SIZE, 256, sample HVs per window
WINDOW_STEP, 128, sample HVs between window starts; must divide WINDOW_SIZE; NUM_ACC = WINDOW_SIZE/WINDOW_STEP

Ports:
clk  in  1  clock
nrst  in  1  synchronous active-low reset
in_valid  in  1  sample valid
in_ready  out  1  sample accepted when in_valid && in_ready
samples  in  NUM_CHS*SAMPLE_W  signed; channel c at [c*SAMPLE_W +: SAMPLE_W]
ch_hv  in  NUM_CHS*DIMENSIONS  channel item HVs, static
lbp_hv  in  NUM_LBP*DIMENSIONS  LBP item HVs, static
out_valid  out  1  window HV available
out_ready  in  1  consumer accept
window_hv  out  DIMENSIONS  bundled window HV

Behaviour:
- Reset (nrst=0 at posedge clk, synchronous): state WARMUP; sample history cleared to 0; all accumulators, armed bits and counters cleared; out_valid=0; window_hv=0. Reset mid-window discards partial windows and any pending output.
- in_ready = !out_valid || out_ready. Combinational, no dependency on in_valid.
- History per channel: LBP_SIZE+1 samples, shifted on every accept; newest at index LBP_SIZE.
- Pattern bit j-1 (j=LBP_SIZE..1) = 1 if hist[j] <= hist[j-1] (signed: falling or equal), else 0. The pattern value indexes lbp_hv.
- Sample HV: bound[c] = lbp_hv[pattern[c]] ^ ch_hv[c]. Per bit, 1 if 2*ones > NUM_CHS. On an exact tie (even NUM_CHS) the bit takes bound[0].
- FSM: WARMUP takes the first LBP_SIZE accepts, which fill history only and produce no sample HV. It then moves to RUN. Every RUN accept produces one sample HV, computed combinationally and accumulated in the same edge.
- Sample index idx counts 0..WINDOW_SIZE-1, wraps, and advances on each RUN accept.
- Accumulators: NUM_ACC banks, each with DIMENSIONS counters of $clog2(WINDOW_SIZE+1) bits. Every armed bank adds the sample HV.
- Bank k is cleared and armed when idx == k*WINDOW_STEP, and this includes the current sample.
- Completion: when (idx+1) % WINDOW_STEP == 0, bank j = ((idx+1)/WINDOW_STEP) % NUM_ACC completes, but only if it is already armed.
  - Each window_hv bit = 1 iff 2*count > WINDOW_SIZE; a tie gives 0.
  - Final sample is included.
  - out_valid=1 on the next cycle.
  - Bank cleared for its restart.
- Latency: out_valid rises the cycle after the completing accept. The first window needs LBP_SIZE+WINDOW_SIZE accepts; later windows come every WINDOW_STEP accepts.
- window_hv is held stable while out_valid && !out_ready. out_valid clears on the handshake unless the same-cycle accept completes a new window; in that case window_hv reloads and out_valid stays 1.
- in_valid=0 leaves all state frozen.

Optional Feature:
LBP_SAMPLE_TAP_EN: when defined, adds two outputs. sample_hv_tap (DIMENSIONS) is registered and carries each RUN sample HV. sample_tap_valid is a one-cycle pulse the cycle after the accept. When undefined, neither port nor its registers exist, and the behaviour above is unchanged.

Decomposition:
- Package hdc_lbp_pkg holds:
  - localparam helpers NUM_LBP and NUM_ACC
  - the counter-width function
  - FSM state enum {WARMUP, RUN}
  - majority-threshold functions for the channel and window rules, including the tie rules
- Sub-module lbp_window_accumulator is one counter bank with clear/arm/add/threshold. It is instantiated NUM_ACC times in a generate loop.

Test Plan:
Common bench configuration: DIMENSIONS=16, NUM_CHS=3, SAMPLE_W=8, LBP_SIZE=2, WINDOW_SIZE=4, WINDOW_STEP=2, out_ready=1 unless stated.
- Ramp: all channels 0,1,2,… every cycle -> patterns 0; first out_valid after accept 6, then after accepts 8, 10, 12. window_hv = bitwise majority of lbp_hv[0]^ch_hv[c].
- Constant samples -> pattern 3 (equal counts as 1); window_hv = majority of lbp_hv[3]^ch_hv[c].
- Alternating sample HVs A,B,A,B (steep up/down patterns) -> window_hv = A&B (bits tied at 2 of 4 give 0).
- Backpressure: out_ready=0 at first window -> in_ready=0, window_hv stable for 10 cycles. After release, the next window follows after exactly 2 more accepts with no sample lost.
- Reset at accept 5: pulse nrst=0 -> out_valid=0; the next window appears only after 6 fresh accepts.
- With LBP_SAMPLE_TAP_EN: ramp -> sample_tap_valid pulses on accepts 3..N, never during warmup.
